// File: rtl/cpld_slave_if_if.sv
`timescale 1ns/1ps
// Purpose : serial-link and board-I/O bundle for the CPLD slave; the host/bench side uses master, the design uses slave.
// Latency : none; this only groups wires.
// Backpr. : none; the serial link is free-running and outputs are level/pulse signals.
// Signals : cpld_rstn/clk/load/mosi (host -> slave), cpld_miso (slave -> host),
//           sw (switch levels in), led/seg/an (display drive out), frame/frame_err (status out).
interface cpld_slave_if_if;
    logic       cpld_rstn_i;
    logic       cpld_clk_i;
    logic       cpld_load_i;
    logic       cpld_mosi_i;
    logic       cpld_miso_o;
    logic [7:0] sw_i;
    logic [7:0] led_o;
    logic [7:0] seg_o;
    logic [1:0] an_o;
    logic       frame_o;
    logic       frame_err_o;

    modport slave (
        input  cpld_rstn_i, cpld_clk_i, cpld_load_i, cpld_mosi_i, sw_i,
        output cpld_miso_o, led_o, seg_o, an_o, frame_o, frame_err_o
    );

    modport master (
        output cpld_rstn_i, cpld_clk_i, cpld_load_i, cpld_mosi_i, sw_i,
        input  cpld_miso_o, led_o, seg_o, an_o, frame_o, frame_err_o
    );
endinterface

// File: rtl/cpld_slave_if.sv
`timescale 1ns/1ps
// Purpose : 16-slot serial slave; receives LED/segment frames, returns switch levels, flags framing errors.
// Latency : 4 clk_i cycles from a cpld_clk_i falling pin edge to led_o/seg_o/an_o/frame_o (2 sync + detect + register).
// Backpr. : none; the host owns the serial clock and every frame is accepted.
// Ports   : clk_i/rst_i plain (sync, active-high); bus (slave modport) carries the serial link,
//           sw_i in, and led_o/seg_o (active-low)/an_o (active-low)/frame_o/frame_err_o out.
module cpld_slave_if (
    input  logic           clk_i,
    input  logic           rst_i,
    cpld_slave_if_if.slave bus
);
    // Synchronizers that only rst_i may clear (the host reset cannot clear its own synchronizer).
    logic [1:0]  rstn_sync_q, rstn_sync_d;
    logic [7:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;

    // Link synchronizers: [0] first stage, [1] synchronized, [2] one cycle later.
    // For the clock, [2] is the edge-detect history; load/mosi [2] stay aligned with the registered pulses.
    logic [2:0]  clk_sync_q, clk_sync_d;
    logic [2:0]  load_sync_q, load_sync_d;
    logic [2:0]  mosi_sync_q, mosi_sync_d;
    logic        rise_q, rise_d, fall_q, fall_d;

    logic [15:0] rx_q, rx_d, tx_q, tx_d;
    logic [3:0]  slot_q, slot_d;
    logic        parity_q, parity_d;
    logic [7:0]  led_q, led_d, seg_q, seg_d;
    logic [1:0]  an_q, an_d;
    logic        frame_q, frame_d, err_q, err_d, miso_q, miso_d;

    logic        core_rst;
    logic        frame_end;
    logic        frame_bad;

    assign core_rst = rst_i | ~rstn_sync_q[1];

    always_comb begin
        rstn_sync_d = {rstn_sync_q[0], bus.cpld_rstn_i};
        sw_s1_d     = bus.sw_i;
        sw_s2_d     = sw_s1_q;
        clk_sync_d  = {clk_sync_q[1:0],  bus.cpld_clk_i};
        load_sync_d = {load_sync_q[1:0], bus.cpld_load_i};
        mosi_sync_d = {mosi_sync_q[1:0], bus.cpld_mosi_i};

        rise_d = clk_sync_q[1] & ~clk_sync_q[2];
        fall_d = ~clk_sync_q[1] & clk_sync_q[2];

        // A fall with load high ends a frame; load at the wrong slot, or a missing load at
        // slot 15, is a framing error. Both can be true at once and both take effect.
        frame_end = fall_q & load_sync_q[2];
        frame_bad = fall_q & (load_sync_q[2] ? (slot_q != 4'd15) : (slot_q == 4'd15));

        rx_d = rx_q;
        if (rise_q) begin
            rx_d = {mosi_sync_q[2], rx_q[15:1]};
        end

        slot_d = slot_q;
        tx_d   = tx_q;
        if (fall_q) begin
            slot_d = frame_end ? 4'd0 : slot_q + 4'd1;  // natural 15->0 wrap
            tx_d   = frame_end ? {8'h00, sw_s2_q} : {1'b0, tx_q[15:1]};
        end

        parity_d = parity_q;
        led_d    = led_q;
        seg_d    = seg_q;
        an_d     = an_q;
        if (frame_end) begin
            parity_d = ~parity_q;
            led_d    = rx_q[7:0];
            seg_d    = ~rx_q[15:8];
            an_d     = parity_q ? 2'b10 : 2'b01;
        end

        frame_d = frame_end;
        err_d   = err_q | frame_bad;
        miso_d  = tx_d[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rstn_sync_q <= 2'b11;
            sw_s1_q     <= 8'h00;
            sw_s2_q     <= 8'h00;
        end else begin
            rstn_sync_q <= rstn_sync_d;
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (core_rst) begin
            clk_sync_q  <= 3'b000;
            load_sync_q <= 3'b000;
            mosi_sync_q <= 3'b000;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            rx_q        <= 16'h0000;
            tx_q        <= 16'h0000;
            slot_q      <= 4'd0;
            parity_q    <= 1'b0;
            led_q       <= 8'h00;
            seg_q       <= 8'hFF;
            an_q        <= 2'b11;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            load_sync_q <= load_sync_d;
            mosi_sync_q <= mosi_sync_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            slot_q      <= slot_d;
            parity_q    <= parity_d;
            led_q       <= led_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            miso_q      <= miso_d;
        end
    end

    assign bus.cpld_miso_o = miso_q;
    assign bus.led_o       = led_q;
    assign bus.seg_o       = seg_q;
    assign bus.an_o        = an_q;
    assign bus.frame_o     = frame_q;
    assign bus.frame_err_o = err_q;
endmodule

// File: tb/tb_cpld_slave_if.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for cpld_slave_if; frame results and miso bits go through scoreboards.
// Latency : expects display updates and frame_o 4 clk_i cycles after the serial clock falling edge.
// Backpr. : none; the bench drives the serial clock with >=4-cycle phases.
module tb_cpld_slave_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpld_slave_if_if ifc();
    cpld_slave_if dut (.clk_i(clk), .rst_i(rst), .bus(ifc.slave));

    typedef struct {
        logic [7:0] led;
        logic [7:0] seg;
        logic [1:0] an;
        int         due;
    } exp_t;

    exp_t        fq[$];
    logic        mq[$];
    logic [15:0] m_tx;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit slot: data set mid-low phase, rise, then fall; the fall ends the slot.
    task automatic send_slot(input logic b, input logic ld,
                             input logic [7:0] e_led, input logic [7:0] e_seg, input logic [1:0] e_an);
        ifc.cpld_mosi_i = b;
        ifc.cpld_load_i = ld;
        tick(4);
        mq.push_back(m_tx[0]);
        ifc.cpld_clk_i = 1'b1;
        tick(6);
        ifc.cpld_clk_i = 1'b0;
        if (ld) begin
            exp_t e;
            e.led = e_led;
            e.seg = e_seg;
            e.an  = e_an;
            e.due = cyc + 4;
            fq.push_back(e);
            m_tx = {8'h00, ifc.sw_i};
        end else begin
            m_tx = {1'b0, m_tx[15:1]};
        end
        tick(4);
    endtask

    task automatic send_frame(input logic [15:0] d, input int n,
                              input logic [7:0] e_led, input logic [7:0] e_seg, input logic [1:0] e_an);
        for (int k = 0; k < n; k++) begin
            send_slot(d[k], (k == n - 1), e_led, e_seg, e_an);
        end
        tick(2);
    endtask

    task automatic send_partial(input logic [15:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            send_slot(d[k], 1'b0, 8'h00, 8'h00, 2'b00);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_led"},   32'(ifc.led_o),       32'h00);
        chk({tag, "_seg"},   32'(ifc.seg_o),       32'hFF);
        chk({tag, "_an"},    32'(ifc.an_o),        32'h3);
        chk({tag, "_frame"}, 32'(ifc.frame_o),     32'h0);
        chk({tag, "_err"},   32'(ifc.frame_err_o), 32'h0);
        chk({tag, "_miso"},  32'(ifc.cpld_miso_o), 32'h0);
    endtask

    // Frame scoreboard: every frame_o cycle must match the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (ifc.frame_o === 1'b1) begin
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got frame_o=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = fq.pop_front();
                chk("frame_led", 32'(ifc.led_o), 32'(e.led));
                chk("frame_seg", 32'(ifc.seg_o), 32'(e.seg));
                chk("frame_an",  32'(ifc.an_o),  32'(e.an));
                chk("frame_lat", 32'(cyc),       32'(e.due));
            end
        end
    end

    // Miso scoreboard: the host samples miso on each serial clock rise.
    always @(posedge ifc.cpld_clk_i) begin
        #1;
        if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected: got rise with no expected bit, expected queued bit");
        end else begin
            chk("miso", 32'(ifc.cpld_miso_o), 32'(mq.pop_front()));
        end
    end

    initial begin
        ifc.cpld_rstn_i = 1'b1;
        ifc.cpld_clk_i  = 1'b0;
        ifc.cpld_load_i = 1'b0;
        ifc.cpld_mosi_i = 1'b0;
        ifc.sw_i        = 8'h3C;
        m_tx            = 16'h0000;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_state("reset");

        // led A5, segment pattern 4F ("3") -> active-low B0, first digit select
        send_frame(16'h4FA5, 16, 8'hA5, 8'hB0, 2'b01);
        chk("a_err", 32'(ifc.frame_err_o), 32'h0);

        // miso in this frame carries 3C; switches change for the following frame
        ifc.sw_i = 8'hC3;
        send_frame(16'h1234, 16, 8'h34, 8'hED, 2'b10);
        send_frame(16'hFF00, 16, 8'h00, 8'h00, 2'b01);
        chk("c_err", 32'(ifc.frame_err_o), 32'h0);

        // load at slot 9: accepted with rx = {d[9:0], FF00[15:10]} = 557F
        send_frame(16'h0155, 10, 8'h7F, 8'hAA, 2'b10);
        chk("short_err", 32'(ifc.frame_err_o), 32'h1);
        send_frame(16'h0F0F, 16, 8'h0F, 8'hF0, 2'b01);
        chk("sticky_err", 32'(ifc.frame_err_o), 32'h1);

        // rst_i after slot 6 discards the partial frame
        send_partial(16'hFFFF, 7);
        rst = 1'b1;
        tick(2);
        rst  = 1'b0;
        m_tx = 16'h0000;
        tick(1);
        check_reset_state("rst_mid");
        send_frame(16'h3C81, 16, 8'h81, 8'hC3, 2'b01);
        chk("rst_next_err", 32'(ifc.frame_err_o), 32'h0);

        // host reset low for 3 cycles mid-frame
        send_partial(16'hAAAA, 7);
        ifc.cpld_rstn_i = 1'b0;
        tick(3);
        ifc.cpld_rstn_i = 1'b1;
        m_tx = 16'h0000;
        tick(3);
        check_reset_state("rstn_mid");
        send_frame(16'h7E81, 16, 8'h81, 8'h81, 2'b01);
        chk("rstn_next_err", 32'(ifc.frame_err_o), 32'h0);

        tick(10);
        chk("frames_pending", 32'(fq.size()), 32'h0);
        chk("miso_pending",   32'(mq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpld_slave_if.md
CPLD_SLAVE_IF -- requirements
Module: cpld_slave_if

Interface
REQ-001 clk_i  input  1  system clock; all logic on its rising edge.
REQ-002 rst_i  input  1  reset; synchronous, active-high.
REQ-003 cpld_rstn_i  input  1  host reset from the link; active-low; synchronous clear equivalent to rst_i after synchronization.
REQ-004 cpld_clk_i  input  1  serial clock from host; asynchronous to clk_i.
REQ-005 cpld_load_i  input  1  frame marker; high during bit slot 15.
REQ-006 cpld_mosi_i  input  1  serial data in; LSB first.
REQ-007 cpld_miso_o  output  1  serial data out to host.
REQ-008 sw_i  input  8  switch levels to report; asynchronous.
REQ-009 led_o  output  8  LED drive; active-high.
REQ-010 seg_o  output  8  segment drive, active-low; bit 7 = dp, bits 6:0 = segments g..a.
REQ-011 an_o  output  2  digit enables; active-low.
REQ-012 frame_o  output  1  one-cycle pulse per accepted frame.
REQ-013 frame_err_o  output  1  sticky framing-error flag.

Function
REQ-014 cpld_clk_i, cpld_load_i, cpld_mosi_i, cpld_rstn_i and sw_i SHALL each pass through a 2-flop synchronizer; a third flop on the synchronized clock SHALL give rise/fall detect pulses, one clk_i cycle wide.
REQ-015 Rising edge of synchronized cpld_clk SHALL shift synchronized mosi into a 16-bit register at bit 15, right-shifting the rest; after 16 rises, bit k holds slot k.
REQ-016 A 4-bit slot counter SHALL increment on each falling edge, wrapping 15->0.
REQ-017 Falling edge with synchronized load high SHALL end the frame: on the next clk_i cycle, led_o <= rx[7:0], seg_o <= ~rx[15:8], frame_o = 1 for one cycle, slot counter <= 0.
REQ-018 The frame-end falling edge SHALL also toggle the digit parity bit: parity 0 at frame end -> an_o = 2'b01 (digit 1 on); parity 1 -> an_o = 2'b10 (digit 0 on).
REQ-019 Framing check: if load is high at a falling edge while the slot counter != 15, frame_err_o SHALL set; the frame is still accepted per REQ-017 and the counter resynchronizes to 0.
REQ-020 Falling edges with load low and slot counter == 15 SHALL set frame_err_o; outputs unchanged; counter wraps to 0.
REQ-021 frame_err_o SHALL clear only on rst_i or cpld_rstn_i.
REQ-022 On each frame-end falling edge, the 16-bit tx register SHALL load {8'h00, sw_sync}; on every other falling edge it SHALL shift right, zero-filling.
REQ-023 cpld_miso_o SHALL be registered and equal tx[0]; slot k carries sw[k] for k<8 and 0 for k>=8.
REQ-024 Rise and fall pulses SHALL never occur in the same clk_i cycle; simultaneous frame end and framing error both take effect.
REQ-025 Correct operation SHALL require each cpld_clk_i high and low phase to last >= 4 clk_i cycles; shorter phases are undefined.
REQ-026 Latency from a cpld_clk_i falling pin edge to a led_o/seg_o/an_o update SHALL be 4 clk_i cycles (2 sync + 1 detect + 1 register).

Reset
REQ-027 rst_i or synchronized cpld_rstn_i low SHALL clear on the next clk_i edge: led_o=8'h00, seg_o=8'hFF, an_o=2'b11, frame_o=0, frame_err_o=0, cpld_miso_o=0, slot counter=0, parity=0, rx=0, tx=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first complete 16-slot frame after release SHALL be accepted without error.
REQ-029 Synchronizer flops SHALL also reset: cpld_clk history low, load low.

Verification
REQ-030 Frame led=8'hA5, seg field=8'h4F (digit "3", active-high) -> led_o=8'hA5, seg_o=8'hB0, an_o=2'b01, one frame_o pulse, frame_err_o=0.
REQ-031 Two back-to-back frames -> an_o sequence 2'b01 then 2'b10; third frame -> 2'b01.
REQ-032 sw_i=8'h3C stable; next frame -> miso slots 0..15 = 0,0,1,1,1,1,0,0 then eight 0s.
REQ-033 Load asserted at slot 9 -> frame_err_o=1, accepted, next 16-slot frame aligns correctly; frame_err_o stays 1.
REQ-034 rst_i pulsed after slot 6 of a frame -> outputs at REQ-027 values; next full frame led=8'h81 -> led_o=8'h81, frame_err_o=0.
REQ-035 cpld_rstn_i low for 3 clk_i cycles mid-frame -> same response as REQ-034.
